// File: rtl/degamma_pkg.sv
// Shared widths, config FSM encoding and small helpers for the degamma stage.
package degamma_pkg;
    localparam int PIX_W     = 8;
    localparam int LUT_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int CNT_W     = 11;
    localparam int NUM_CH    = 3;   // [2]=R, [1]=G, [0]=B

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } cfg_state_t;

    typedef logic [NUM_CH-1:0][PIX_W-1:0] pix_vec_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/degamma_lut_bank.sv
// Double-buffered 256x8 LUT: one write port into the shadow bank,
// three registered read ports (R/G/B) from the active bank.
module degamma_lut_bank
    import degamma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              bank_sel,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  pix_vec_t          raddr,
    output pix_vec_t          rdata
);
    logic [PIX_W-1:0] mem [2][LUT_DEPTH];

    // Software only ever writes the bank that is not being read.
    always_ff @(posedge clk) begin
        if (we) mem[~bank_sel][waddr] <= wdata;
    end

    // Synchronous read of all three channels from the active bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) rdata[c] <= mem[bank_sel][raddr[c]];
        end
    end
endmodule

// File: rtl/degamma_top.sv
// Inverse-gamma stage: input register, double-buffered LUT lookup,
// frame-synchronous bank swap FSM and stream geometry checker.
module degamma_top
    import degamma_pkg::*;
#(
    parameter int source_h = 1024,
    parameter int source_v = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [PIX_W-1:0]  in_data_R,
    input  logic [PIX_W-1:0]  in_data_G,
    input  logic [PIX_W-1:0]  in_data_B,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [PIX_W-1:0]  cfg_wdata,
    input  logic              cfg_commit,
    output logic              cfg_ready,
    output logic              cfg_pending,
    input  logic              err_clr,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [PIX_W-1:0]  out_data_R,
    output logic [PIX_W-1:0]  out_data_G,
    output logic [PIX_W-1:0]  out_data_B,
    output logic              fmt_err
);
    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(source_h);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(source_v);

    logic       s1_vsync, s1_hsync, s1_den;
    pix_vec_t   s1_pix;
    logic       s2_vsync, s2_hsync, s2_den, s2_lut_on;
    pix_vec_t   s2_pix, lut_q, out_pix;

    cfg_state_t state, state_nxt;
    logic       swap, shadow_we;
    logic       bank_sel, lut_valid;

    logic [CNT_W-1:0] pix_cnt, line_cnt;
    logic             first_frame;
    logic             vs_rise, den_rise, den_fall, line_bad, frame_bad;

    // The stage-1 register doubles as the previous sample for edge detection.
    assign vs_rise  = in_vsync & ~s1_vsync;
    assign den_rise = in_den & ~s1_den;
    assign den_fall = ~in_den & s1_den;

    // Stage 1: register all inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vsync <= 1'b0;
            s1_hsync <= 1'b0;
            s1_den   <= 1'b0;
            s1_pix   <= '0;
        end else begin
            s1_vsync <= in_vsync;
            s1_hsync <= in_hsync;
            s1_den   <= in_den;
            s1_pix   <= {in_data_R, in_data_G, in_data_B};
        end
    end

    degamma_lut_bank u_lut (
        .clk      (clk),
        .reset    (reset),
        .bank_sel (bank_sel),
        .we       (shadow_we),
        .waddr    (cfg_addr),
        .wdata    (cfg_wdata),
        .raddr    (s1_pix),
        .rdata    (lut_q)
    );

    // Stage 2: syncs, bypass copy and the table-enable seen by this read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vsync  <= 1'b0;
            s2_hsync  <= 1'b0;
            s2_den    <= 1'b0;
            s2_pix    <= '0;
            s2_lut_on <= 1'b0;
        end else begin
            s2_vsync  <= s1_vsync;
            s2_hsync  <= s1_hsync;
            s2_den    <= s1_den;
            s2_pix    <= s1_pix;
            s2_lut_on <= lut_valid;
        end
    end

    assign out_pix    = s2_lut_on ? lut_q : s2_pix;
    assign out_vsync  = s2_vsync;
    assign out_hsync  = s2_hsync;
    assign out_den    = s2_den;
    assign out_data_R = out_pix[2];
    assign out_data_G = out_pix[1];
    assign out_data_B = out_pix[0];

    // Config FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Config FSM: writes only in IDLE; an armed swap fires on vsync rise.
    always_comb begin
        state_nxt   = state;
        swap        = 1'b0;
        shadow_we   = 1'b0;
        cfg_ready   = 1'b0;
        cfg_pending = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                shadow_we = cfg_we;
                if (cfg_commit) state_nxt = ARMED;
            end
            ARMED: begin
                cfg_pending = 1'b1;
                if (vs_rise) begin
                    state_nxt = IDLE;
                    swap      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bank select and table-enable change only at the swap edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel  <= 1'b0;
            lut_valid <= 1'b0;
        end else if (swap) begin
            bank_sel  <= ~bank_sel;
            lut_valid <= 1'b1;
        end
    end

    assign line_bad  = den_fall && (pix_cnt != H_EXP);
    assign frame_bad = vs_rise && !first_frame && (line_cnt != V_EXP);

    // Geometry counters: pixels per den run, den runs per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            first_frame <= 1'b1;
        end else begin
            if (den_rise)    pix_cnt <= CNT_W'(1);
            else if (in_den) pix_cnt <= sat_inc(pix_cnt);
            if (vs_rise) begin
                line_cnt    <= '0;
                first_frame <= 1'b0;
            end else if (den_fall) begin
                line_cnt <= sat_inc(line_cnt);
            end
        end
    end

    // Sticky error; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      fmt_err <= 1'b0;
        else if (err_clr)               fmt_err <= 1'b0;
        else if (line_bad || frame_bad) fmt_err <= 1'b1;
    end
endmodule

// File: tb/tb_degamma_top.sv
// Randomized scoreboard bench for degamma_top with a table-level reference model.
module tb_degamma_top;
    localparam int H = 1024;
    localparam int V = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_vsync = 0, in_hsync = 0, in_den = 0;
    logic [7:0] in_r = 0, in_g = 0, in_b = 0;
    logic       cfg_we = 0, cfg_commit = 0, err_clr = 0;
    logic [7:0] cfg_addr = 0, cfg_wdata = 0;
    logic       cfg_ready, cfg_pending, fmt_err;
    logic       out_vsync, out_hsync, out_den;
    logic [7:0] out_r, out_g, out_b;

    degamma_top #(.source_h(H), .source_v(V)) dut (
        .clk(clk), .reset(rst),
        .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
        .in_data_R(in_r), .in_data_G(in_g), .in_data_B(in_b),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .cfg_pending(cfg_pending),
        .err_clr(err_clr),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
        .out_data_R(out_r), .out_data_G(out_g), .out_data_B(out_b),
        .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic vs, hs, den;
        logic [7:0] r, g, b;
    } obs_t;
    typedef struct {
        obs_t o;
        int   due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wq[$];          // pending table writes {addr, data}
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // Reference state: the active table, the table software is filling,
    // whether a swap is armed, and the stream geometry seen so far.
    logic [7:0] m_act[256];
    logic [7:0] m_shd[256];
    logic       m_armed, m_valid, m_pvs, m_pden, m_first, m_err;
    int         m_run, m_lines;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_valid = 0; m_pvs = 0; m_pden = 0;
        m_first = 1; m_err = 0; m_run = 0; m_lines = 0;
    endtask

    function automatic logic [7:0] lookup(input logic [7:0] x);
        return m_valid ? m_act[x] : x;
    endfunction

    // One pixel clock: drive, advance the model, queue the expected output.
    task automatic step(input logic vs, input logic hs, input logic den,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic cm, input logic clr);
        exp_t e;
        logic vr, dr, df, eset;
        logic [7:0] tmp;
        @(negedge clk);
        in_vsync = vs; in_hsync = hs; in_den = den;
        in_r = r; in_g = g; in_b = b;
        cfg_we = we; cfg_addr = wa; cfg_wdata = wd; cfg_commit = cm; err_clr = clr;

        vr = vs && !m_pvs;
        dr = den && !m_pden;
        df = !den && m_pden;
        if (m_armed) begin
            if (vr) begin
                for (int i = 0; i < 256; i++) begin
                    tmp = m_act[i]; m_act[i] = m_shd[i]; m_shd[i] = tmp;
                end
                m_valid = 1;
                m_armed = 0;
            end
        end else begin
            if (we) m_shd[wa] = wd;
            if (cm) m_armed = 1;
        end
        e.o = '{vs: vs, hs: hs, den: den, r: lookup(r), g: lookup(g), b: lookup(b)};
        e.due = cyc + 2;
        sb.push_back(e);

        eset = (df && m_run != H) || (vr && !m_first && m_lines != V);
        if (vr) begin
            m_lines = 0; m_first = 0;
        end else if (df) begin
            m_lines++;
        end
        if (dr) m_run = 1;
        else if (den && m_run < 2047) m_run++;
        if (clr) m_err = 0;
        else if (eset) m_err = 1;
        m_pvs = vs; m_pden = den;

        @(posedge clk); #1;
        chk("cfg_pending", 32'(cfg_pending), 32'(m_armed));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_armed));
        chk("fmt_err", 32'(fmt_err), 32'(m_err));
    endtask

    // One frame: 4 vsync cycles, 4 blank, then V lines of den plus 4 blank each.
    task automatic frame(input int commit_at, input int write_from, input int clr_at,
                         input bit short_line, input int abort_at);
        bit dq[$];
        logic we;
        logic [15:0] w;
        logic [7:0] r;
        for (int i = 0; i < 8; i++) dq.push_back(1'b0);
        for (int l = 0; l < V; l++) begin
            for (int i = 0; i < ((short_line && l == 0) ? H - 1 : H); i++) dq.push_back(1'b1);
            for (int i = 0; i < 4; i++) dq.push_back(1'b0);
        end
        for (int t = 0; t < dq.size(); t++) begin
            we = (write_from >= 0) && (t >= write_from) && (wq.size() > 0);
            w = we ? wq.pop_front() : 16'h0;
            r = (t % 8 == 0) ? 8'h80 : 8'($urandom);
            step(t < 4, 1'($urandom), dq[t], r, 8'($urandom), 8'($urandom),
                 we, w[15:8], w[7:0], t == commit_at, t == clr_at);
            if (t == abort_at) return;
        end
    endtask

    // Monitor: compare the DUT output against whichever expectation is due.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                while (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    a = '{vs: out_vsync, hs: out_hsync, den: out_den, r: out_r, g: out_g, b: out_b};
                    if (e.due != cyc) chk("sb_late", 32'(e.due), 32'(cyc));
                    else chk("pixel_out", 32'(a), 32'(e.o));
                end
            end
        end
    end

    initial begin
        int g;
        for (int i = 0; i < 256; i++) begin m_act[i] = 0; m_shd[i] = 0; end
        model_reset();

        // Outputs held at zero while reset is high, whatever the inputs do.
        repeat (3) begin
            @(negedge clk);
            in_vsync = 1; in_den = 1; in_r = 8'h40; in_g = 8'h80; in_b = 8'hC0;
            @(posedge clk); #1;
            chk("reset_out", 32'({out_vsync, out_hsync, out_den, out_r, out_g, out_b}), 32'h0);
            chk("reset_cfg", 32'({cfg_ready, cfg_pending, fmt_err}), 32'b100);
        end
        @(negedge clk);
        in_vsync = 0; in_den = 0; in_r = 0; in_g = 0; in_b = 0;
        rst = 0;

        // Identity bypass before any table is committed.
        repeat (4) step(0, 0, 0, 8'h40, 8'h80, 8'hC0, 0, 0, 0, 0, 0);
        frame(-1, -1, -1, 0, -1);

        // Load a 2.2 decode table, commit mid-frame; swap at next vsync rise.
        for (int i = 0; i < 256; i++) begin
            g = $rtoi(255.0 * ((real'(i) / 255.0) ** 2.2));
            wq.push_back({8'(i), 8'(g)});
        end
        frame(1500, 10, -1, 0, -1);
        // Swap happens at start; meanwhile fill the other bank with an inverse ramp.
        for (int i = 0; i < 256; i++) wq.push_back({8'(i), 8'(255 - i)});
        frame(-1, 10, -1, 0, -1);

        // Write while armed is dropped; two swaps later the decode table is intact.
        wq.push_back({8'h05, 8'hAA});
        frame(300, 500, -1, 0, -1);
        frame(100, -1, -1, 0, -1);
        frame(-1, -1, -1, 0, -1);

        // Commit on the vsync-rise cycle only arms; the swap waits a frame.
        frame(0, -1, -1, 0, -1);
        frame(-1, -1, -1, 0, -1);

        // Short line raises fmt_err, clear drops it, exact lines keep it low.
        frame(-1, -1, 1500, 1, -1);
        frame(-1, -1, -1, 0, -1);

        // Reset while armed mid-frame.
        frame(50, -1, -1, 0, 700);
        #2 rst = 1;
        #1;
        chk("midreset_out", 32'({out_vsync, out_hsync, out_den, out_r, out_g, out_b}), 32'h0);
        chk("midreset_pending", 32'(cfg_pending), 32'h0);
        sb.delete();
        model_reset();
        @(negedge clk);
        in_vsync = 0; in_den = 0; in_hsync = 0; cfg_we = 0; cfg_commit = 0; err_clr = 0;
        @(negedge clk);
        rst = 0;
        frame(-1, -1, -1, 0, -1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
